// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares one single-port 512-word memory between the core
// load/store path (port 0) and a secondary master (port 1). Round-robin
// grant, short locked sequences with a forced release, memory-map access
// checking and a registered one-cycle response per accepted transfer.
module lsu_arbiter #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_we_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  input  logic              req0_lock_i,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_we_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  input  logic              req1_lock_i,

  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp0_rdata_o,
  output logic              rsp0_err_o,

  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp1_rdata_o,
  output logic              rsp1_err_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  // Memory map boundaries (word addresses)
  localparam logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(320);
  localparam logic [ADDR_W-1:0] RSV_BASE = ADDR_W'(384);
  localparam logic [CNT_W-1:0]  LOCK_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic [CNT_W-1:0]  r_lock_cnt;
  logic [CNT_W-1:0]  w_lock_cnt_nxt;
  logic [CNT_W-1:0]  w_lock_cnt_inc;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic              w_sel;
  logic              w_we;
  logic              w_lock;
  logic              w_err;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  logic              r_rsp0_valid;
  logic [DATA_W-1:0] r_rsp0_rdata;
  logic              r_rsp0_err;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp1_rdata;
  logic              r_rsp1_err;

  // Reserved space is never accessible; input peripherals are read-only.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic we);
    return (a >= RSV_BASE) || (we && (a >= IN_BASE));
  endfunction

  // State register: arbitration state, last-granted port, lock length
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ARB;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Output decode: grant per state, forced low while in reset
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case (r_state)
      ARB: begin
        w_gnt0 = req0_valid_i && (!req1_valid_i || r_last);
        w_gnt1 = req1_valid_i && (!req0_valid_i || !r_last);
      end
      LOCK0:   w_gnt0 = req0_valid_i;
      LOCK1:   w_gnt1 = req1_valid_i;
      default: ;
    endcase
    if (!rst_ni) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign req0_ready_o = w_gnt0;
  assign req1_ready_o = w_gnt1;

  // Granted-port request mux and access check
  always_comb begin
    w_acc   = w_gnt0 || w_gnt1;
    w_sel   = w_gnt1;
    w_we    = w_sel ? req1_we_i    : req0_we_i;
    w_lock  = w_sel ? req1_lock_i  : req0_lock_i;
    w_addr  = w_sel ? req1_addr_i  : req0_addr_i;
    w_wdata = w_sel ? req1_wdata_i : req0_wdata_i;
    w_err   = addr_err(w_addr, w_we);
  end

  // Memory drive: pass the granted request through, all zero when idle
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    if (w_acc) begin
      mem_addr_o  = w_addr;
      mem_wdata_o = w_wdata;
      mem_we_o    = w_we && !w_err;
    end
  end

  // Next-state logic: lock entry/continuation/release and round-robin pointer.
  // lock_cnt holds the number of locked grants made so far in the current
  // sequence; the grant that would make it MAX_LOCK ends the lock, and since
  // last then points at the lock owner the other port wins the next tie.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_lock_cnt_nxt = r_lock_cnt;
    w_lock_cnt_inc = (r_state == ARB) ? CNT_W'(1) : r_lock_cnt + CNT_W'(1);
    if (w_acc) begin
      w_last_nxt = w_sel;
      if (w_lock && (w_lock_cnt_inc < LOCK_MAX)) begin
        w_state_nxt    = w_sel ? LOCK1 : LOCK0;
        w_lock_cnt_nxt = w_lock_cnt_inc;
      end else begin
        w_state_nxt    = ARB;
        w_lock_cnt_nxt = '0;
      end
    end else if (r_state != ARB) begin
      // lock owner dropped valid: release without a transfer
      w_state_nxt    = ARB;
      w_lock_cnt_nxt = '0;
    end
  end

  // Response registers: one-cycle pulse to the accepting port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_rdata <= '0;
      r_rsp1_err   <= 1'b0;
    end else begin
      r_rsp0_valid <= w_gnt0;
      r_rsp0_err   <= w_gnt0 && w_err;
      r_rsp0_rdata <= (w_gnt0 && !w_we && !w_err) ? mem_rdata_i : '0;
      r_rsp1_valid <= w_gnt1;
      r_rsp1_err   <= w_gnt1 && w_err;
      r_rsp1_rdata <= (w_gnt1 && !w_we && !w_err) ? mem_rdata_i : '0;
    end
  end

  assign rsp0_valid_o = r_rsp0_valid;
  assign rsp0_rdata_o = r_rsp0_rdata;
  assign rsp0_err_o   = r_rsp0_err;
  assign rsp1_valid_o = r_rsp1_valid;
  assign rsp1_rdata_o = r_rsp1_rdata;
  assign rsp1_err_o   = r_rsp1_err;

endmodule
